// File: rtl/regfile_dumper_if.sv
// Output word stream of regfile_dumper: register value tagged with its source
// address and a last-word marker, under a valid/ready handshake.
interface regfile_dumper_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;

    modport master (output out_valid, out_data, out_addr, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_addr, out_last, output out_ready);
endinterface

// File: rtl/regfile_dumper.sv
// Read-side sequencer: walks the register file over an inclusive, wrapping address
// range and streams each word out. Optional checksum port: REGFILE_DUMPER_CHECKSUM_EN.
module regfile_dumper #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    regfile_dumper_if.master  stream
`ifdef REGFILE_DUMPER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    logic [1:0]        state;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W-1:0] span;
    logic              load;
    logic              handshake;
    logic              outValid;
    logic              outLast;
    logic [DATA_W-1:0] outData;
    logic [ADDR_W-1:0] outAddr;

    // Modular subtraction gives the wrapped distance; +1 makes the range inclusive.
    assign span      = last_addr - first_addr;
    assign load      = (state == READ) && (!outValid || stream.out_ready);
    assign handshake = outValid && stream.out_ready;
    assign busy      = (state != IDLE);

    assign stream.out_valid = outValid;
    assign stream.out_data  = outData;
    assign stream.out_addr  = outAddr;
    assign stream.out_last  = outLast;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            remaining <= '0;
            rd_addr   <= '0;
            outValid  <= 1'b0;
            outLast   <= 1'b0;
            outData   <= '0;
            outAddr   <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rd_addr   <= first_addr;
                        remaining <= {1'b0, span} + CNT_ONE;
                        state     <= READ;
                    end
                end
                READ: begin
                    if (load) begin
                        outData   <= rd_data;
                        outAddr   <= rd_addr;
                        outLast   <= (remaining == CNT_ONE);
                        outValid  <= 1'b1;
                        rd_addr   <= rd_addr + ADDR_ONE;
                        remaining <= remaining - CNT_ONE;
                        if (remaining == CNT_ONE) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        outValid <= 1'b0;
                        outLast  <= 1'b0;
                        done     <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef REGFILE_DUMPER_CHECKSUM_EN
    // A start is only taken in IDLE, where no word is in flight, so clear and
    // accumulate never coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (handshake) begin
            checksum <= checksum ^ outData;
        end
    end
`endif
endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: a driver issues dumps and queues the expected
// words; a monitor pops and compares on every handshake.
module tb_regfile_dumper;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  firstAddr;
    logic [3:0]  lastAddr;
    logic        busy;
    logic        done;
    logic [3:0]  rdAddr;
    logic [31:0] rdData;
`ifdef REGFILE_DUMPER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    regfile_dumper_if #(.ADDR_W(4), .DATA_W(32)) sif ();

    regfile_dumper #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .first_addr (firstAddr),
        .last_addr  (lastAddr),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rdAddr),
        .rd_data    (rdData),
        .stream     (sif)
`ifdef REGFILE_DUMPER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] regs [16];
    assign rdData = regs[rdAddr];

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t       expQ[$];
    logic [31:0] chkQ[$];
    int          checks = 0;
    int          passes = 0;
    int          readyMode = 0;
    int          readyPhase = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passes++;
    endtask

    // Ready source: 0 always ready, 1 pattern 1,0,0, 2 random, 3 never ready.
    initial begin
        sif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       sif.out_ready = 1'b1;
                1:       sif.out_ready = (readyPhase % 3 == 0);
                2:       sif.out_ready = 1'($urandom_range(0, 1));
                default: sif.out_ready = 1'b0;
            endcase
            readyPhase++;
        end
    end

    // Monitor: samples on the falling edge, when inputs for the next edge are settled.
    initial begin
        word_t       e;
        logic        stalled = 1'b0;
        logic        pendDone = 1'b0;
        logic [31:0] hData;
        logic [3:0]  hAddr;
        logic [3:0]  hRd;
        logic        hLast;
        logic [31:0] expChk;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled  = 1'b0;
                pendDone = 1'b0;
            end else begin
                if (pendDone) begin
                    check("done_pulse", 64'(done), 64'd1);
                    check("busy_low_in_done", 64'(busy), 64'd0);
                    expChk = (chkQ.size() > 0) ? chkQ.pop_front() : 32'hDEAD_BEEF;
`ifdef REGFILE_DUMPER_CHECKSUM_EN
                    check("checksum", 64'(checksum), 64'(expChk));
`endif
                    pendDone = 1'b0;
                end else if (done) begin
                    check("spurious_done", 64'(done), 64'd0);
                end
                if (stalled && sif.out_valid) begin
                    check("stall_data", 64'(sif.out_data), 64'(hData));
                    check("stall_addr", 64'(sif.out_addr), 64'(hAddr));
                    check("stall_last", 64'(sif.out_last), 64'(hLast));
                    check("stall_rd_addr", 64'(rdAddr), 64'(hRd));
                end
                if (sif.out_valid && sif.out_ready) begin
                    if (expQ.size() == 0) begin
                        check("unexpected_word", 64'(sif.out_valid), 64'd0);
                    end else begin
                        e = expQ.pop_front();
                        check("word_addr", 64'(sif.out_addr), 64'(e.addr));
                        check("word_data", 64'(sif.out_data), 64'(e.data));
                        check("word_last", 64'(sif.out_last), 64'(e.last));
                        if (sif.out_last) pendDone = 1'b1;
                    end
                end
                stalled = sif.out_valid && !sif.out_ready;
                hData = sif.out_data;
                hAddr = sif.out_addr;
                hLast = sif.out_last;
                hRd   = rdAddr;
            end
        end
    end

    task automatic run_dump(input logic [3:0] f, input logic [3:0] l, input int mode,
                            input bit inject);
        int          n;
        int          cyc;
        int          a;
        logic [31:0] x;
        word_t       w;
        n = ((int'(l) - int'(f)) & 15) + 1;
        x = '0;
        for (int i = 0; i < n; i++) begin
            a = (int'(f) + i) % 16;
            w.addr = 4'(a);
            w.data = regs[a];
            w.last = (i == n - 1);
            expQ.push_back(w);
            x ^= regs[a];
        end
        chkQ.push_back(x);
        @(negedge clk);
        readyMode  = mode;
        readyPhase = 0;
        firstAddr  = f;
        lastAddr   = l;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("rd_addr_first", 64'(rdAddr), 64'(f));
        cyc = 1;
        while (!done && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (inject && cyc == 4) begin
                firstAddr = 4'd3;
                lastAddr  = 4'd5;
                start     = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("dump_finished", 64'(done), 64'd1);
        if (mode == 0) check("dump_cycles", 64'(cyc), 64'(n + 2));
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        firstAddr = '0;
        lastAddr  = '0;
        for (int k = 0; k < 16; k++) regs[k] = 32'hA500_0000 + 32'(k);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_valid", 64'(sif.out_valid), 64'd0);
        check("rst_last", 64'(sif.out_last), 64'd0);
        check("rst_rd_addr", 64'(rdAddr), 64'd0);
        check("rst_out_addr", 64'(sif.out_addr), 64'd0);
        check("rst_out_data", 64'(sif.out_data), 64'd0);
`ifdef REGFILE_DUMPER_CHECKSUM_EN
        check("rst_checksum", 64'(checksum), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        run_dump(4'd0, 4'd15, 0, 1'b0);
        run_dump(4'd14, 4'd1, 0, 1'b0);
        run_dump(4'd7, 4'd7, 0, 1'b0);
        run_dump(4'd0, 4'd15, 1, 1'b0);
        run_dump(4'd0, 4'd15, 0, 1'b1);

        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 16; k++) regs[k] = $urandom;
            run_dump(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2, 1'b0);
        end

        for (int k = 0; k < 4; k++) regs[k] = 32'h1 << k;
        run_dump(4'd0, 4'd3, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", 64'(expQ.size()), 64'd0);

        // Abort a dump with a word held by backpressure.
        for (int k = 0; k < 16; k++) regs[k] = 32'hA500_0000 + 32'(k);
        @(negedge clk);
        readyMode = 3;
        firstAddr = 4'd0;
        lastAddr  = 4'd15;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 20 && !sif.out_valid; c++) begin
            @(posedge clk);
            #1;
        end
        check("abort_word_in_flight", 64'(sif.out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(sif.out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_rd_addr", 64'(rdAddr), 64'd0);
        expQ.delete();
        chkQ.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        readyMode = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("no_stale_word", 64'(sif.out_valid), 64'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
